// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, types and helpers for the multi-port register file.
// Holds the default geometry, the storage reset value and the scoreboard
// next-state helper used by regfile_scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_AW       = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_AW-1:0]     reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  // Single bit replicated to the register width on reset.
  localparam logic RST_VAL = 1'b0;

  // A new producer (set) always beats a completion or squash (clr).
  function automatic logic sbNext(input logic busy, input logic clr, input logic set);
    return set | (busy & ~clr);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: issue / writeback / read bundle of the register file.
//   wr_en, wr_addr, wr_data      writeback port (DR, Buss)
//   rd_addr, rd_data, rd_busy    NUM_RD combinational read ports with hazard bit
//   claim_en, claim_addr         issue-time destination claim
//   flush                        squash all pending producers
//   busy_vec, err_unclaimed      scoreboard state and sticky protocol error
// master = pipeline side, slave = register file.
interface regfile_mp_if #(
  parameter int DATA_W   = regfile_pkg::DEF_DATA_W,
  parameter int NUM_REGS = regfile_pkg::DEF_NUM_REGS,
  parameter int NUM_RD   = regfile_pkg::DEF_NUM_RD
);
  localparam int AW = $clog2(NUM_REGS);

  logic                           wr_en;
  logic [AW-1:0]                  wr_addr;
  logic [DATA_W-1:0]              wr_data;
  logic [NUM_RD-1:0][AW-1:0]      rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;
  logic [NUM_RD-1:0]              rd_busy;
  logic                           claim_en;
  logic [AW-1:0]                  claim_addr;
  logic                           flush;
  logic [NUM_REGS-1:0]            busy_vec;
  logic                           err_unclaimed;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, claim_en, claim_addr, flush,
    input  rd_data, rd_busy, busy_vec, err_unclaimed
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, claim_en, claim_addr, flush,
    output rd_data, rd_busy, busy_vec, err_unclaimed
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits plus the sticky unclaimed-write flag.
//   clk, rst_n              clock, asynchronous active-low reset
//   claim_en, claim_addr    mark a register as having a pending producer
//   wr_en, wr_addr          writeback completes the pending producer
//   flush                   clears every busy bit
//   busy_vec                registered scoreboard state
//   err_unclaimed           registered, sticky until reset
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        claim_en,
  input  logic [$clog2(NUM_REGS)-1:0] claim_addr,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic                        flush,
  output logic [NUM_REGS-1:0]         busy_vec,
  output logic                        err_unclaimed
);

  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busyNext_s;
  logic                err_r;
  logic                errNext_s;

  // Next busy state: flush or a write clears, a claim sets and takes priority.
  always_comb begin
    busyNext_s = busy_r;
    for (int r = 0; r < NUM_REGS; r++) begin
      busyNext_s[r] = sbNext(busy_r[r],
                             flush | (wr_en & (wr_addr == AW'(r))),
                             claim_en & (claim_addr == AW'(r)));
    end
  end

  // A write squashed by a flush in the same cycle is never an error.
  always_comb begin
    errNext_s = err_r | (wr_en & ~busy_r[wr_addr] & ~flush);
  end

  // Scoreboard and error state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NUM_REGS{1'b0}};
      err_r  <= 1'b0;
    end else begin
      busy_r <= busyNext_s;
      err_r  <= errNext_s;
    end
  end

  assign busy_vec      = busy_r;
  assign err_unclaimed = err_r;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with busy scoreboard.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          regfile_mp_if.slave: writeback port, NUM_RD read ports with
//                hazard bits, claim/flush inputs, busy_vec and err_unclaimed.
// Reads are combinational; with BYPASS=1 a same-cycle write is forwarded to
// matching read ports and masks their hazard bit.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);

  localparam int   AW        = $clog2(NUM_REGS);
  localparam logic BYPASS_ON = (BYPASS != 0);

  logic [DATA_W-1:0]             regArray_r [NUM_REGS];
  logic [NUM_REGS-1:0]           busyVec_s;
  logic                          errUnclaimed_s;
  logic [NUM_RD-1:0][DATA_W-1:0] rdData_s;
  logic [NUM_RD-1:0]             rdBusy_s;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) uScoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .claim_en      (bus.claim_en),
    .claim_addr    (bus.claim_addr),
    .wr_en         (bus.wr_en),
    .wr_addr       (bus.wr_addr),
    .flush         (bus.flush),
    .busy_vec      (busyVec_s),
    .err_unclaimed (errUnclaimed_s)
  );

  // Register storage; the write lands regardless of scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regArray_r[i] <= {DATA_W{RST_VAL}};
      end
    end else if (bus.wr_en) begin
      regArray_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : gRdPort
    logic [AW-1:0] addr_s;
    logic          hit_s;

    assign addr_s = bus.rd_addr[p];
    // Forwarded data is by definition available, so it also clears the hazard.
    assign hit_s       = BYPASS_ON & bus.wr_en & (bus.wr_addr == addr_s);
    assign rdData_s[p] = hit_s ? bus.wr_data : regArray_r[addr_s];
    assign rdBusy_s[p] = hit_s ? 1'b0 : busyVec_s[addr_s];
  end

  assign bus.rd_data       = rdData_s;
  assign bus.rd_busy       = rdBusy_s;
  assign bus.busy_vec      = busyVec_s;
  assign bus.err_unclaimed = errUnclaimed_s;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table on the default configuration, hand
// sequences for BYPASS=0, the 32x16x3 configuration and mid-cycle reset.
module tb_regfile_mp;

  logic clk;
  logic rst_n;

  regfile_mp_if #(.DATA_W(16), .NUM_REGS(8),  .NUM_RD(2)) ifA ();
  regfile_mp_if #(.DATA_W(16), .NUM_REGS(8),  .NUM_RD(2)) ifB ();
  regfile_mp_if #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) ifC ();

  regfile_mp #(.DATA_W(16), .NUM_REGS(8),  .NUM_RD(2), .BYPASS(1)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  regfile_mp #(.DATA_W(16), .NUM_REGS(8),  .NUM_RD(2), .BYPASS(0)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
  regfile_mp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3), .BYPASS(1)) dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wrEn;
    logic [2:0]  wrAddr;
    logic [15:0] wrData;
    logic        claimEn;
    logic [2:0]  claimAddr;
    logic        flush;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic [1:0]  expBusy;
    logic [7:0]  expVec;
    logic        expErr;
  } vec_t;

  vec_t vecs [15];
  int   total = 0;
  int   bad   = 0;

  // reference state for the randomised 16-register run
  logic [15:0] mBusy;
  logic        mErr;
  logic [31:0] mMem [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idleAll();
    ifA.wr_en = 1'b0; ifA.wr_addr = 3'd0; ifA.wr_data = 16'h0;
    ifA.claim_en = 1'b0; ifA.claim_addr = 3'd0; ifA.flush = 1'b0;
    ifA.rd_addr[0] = 3'd0; ifA.rd_addr[1] = 3'd0;
    ifB.wr_en = 1'b0; ifB.wr_addr = 3'd0; ifB.wr_data = 16'h0;
    ifB.claim_en = 1'b0; ifB.claim_addr = 3'd0; ifB.flush = 1'b0;
    ifB.rd_addr[0] = 3'd0; ifB.rd_addr[1] = 3'd0;
    ifC.wr_en = 1'b0; ifC.wr_addr = 4'd0; ifC.wr_data = 32'h0;
    ifC.claim_en = 1'b0; ifC.claim_addr = 4'd0; ifC.flush = 1'b0;
    for (int p = 0; p < 3; p++) ifC.rd_addr[p] = 4'd0;
  endtask

  initial begin
    //          wr wa    wd        cl ca    fl  ra0   ra1   exp0      exp1      busy   vec    err
    vecs[0]  = '{1'b0,3'd0,16'h0000,1'b1,3'd2,1'b0,3'd2,3'd5,16'h0000,16'h0000,2'b00,8'h04,1'b0};
    vecs[1]  = '{1'b0,3'd0,16'h0000,1'b0,3'd0,1'b0,3'd2,3'd2,16'h0000,16'h0000,2'b11,8'h04,1'b0};
    vecs[2]  = '{1'b0,3'd0,16'h0000,1'b1,3'd6,1'b0,3'd6,3'd2,16'h0000,16'h0000,2'b10,8'h44,1'b0};
    vecs[3]  = '{1'b1,3'd2,16'h00AA,1'b0,3'd0,1'b0,3'd2,3'd6,16'h00AA,16'h0000,2'b10,8'h40,1'b0};
    vecs[4]  = '{1'b1,3'd6,16'h5555,1'b1,3'd6,1'b0,3'd6,3'd2,16'h5555,16'h00AA,2'b00,8'h40,1'b0};
    vecs[5]  = '{1'b0,3'd0,16'h0000,1'b0,3'd0,1'b0,3'd6,3'd6,16'h5555,16'h5555,2'b11,8'h40,1'b0};
    vecs[6]  = '{1'b0,3'd0,16'h0000,1'b1,3'd0,1'b0,3'd0,3'd7,16'h0000,16'h0000,2'b00,8'h41,1'b0};
    vecs[7]  = '{1'b0,3'd0,16'h0000,1'b1,3'd7,1'b0,3'd0,3'd7,16'h0000,16'h0000,2'b01,8'hC1,1'b0};
    vecs[8]  = '{1'b0,3'd0,16'h0000,1'b1,3'd1,1'b1,3'd1,3'd7,16'h0000,16'h0000,2'b10,8'h02,1'b0};
    vecs[9]  = '{1'b1,3'd3,16'h3333,1'b0,3'd0,1'b1,3'd3,3'd1,16'h3333,16'h0000,2'b10,8'h00,1'b0};
    vecs[10] = '{1'b1,3'd5,16'h1234,1'b0,3'd0,1'b0,3'd5,3'd3,16'h1234,16'h3333,2'b00,8'h00,1'b1};
    vecs[11] = '{1'b1,3'd4,16'h0F0F,1'b0,3'd0,1'b0,3'd4,3'd5,16'h0F0F,16'h1234,2'b00,8'h00,1'b1};
    vecs[12] = '{1'b0,3'd0,16'h0000,1'b1,3'd4,1'b0,3'd4,3'd2,16'h0F0F,16'h00AA,2'b00,8'h10,1'b1};
    vecs[13] = '{1'b1,3'd4,16'hAAAA,1'b0,3'd0,1'b0,3'd4,3'd4,16'hAAAA,16'hAAAA,2'b00,8'h00,1'b1};
    vecs[14] = '{1'b0,3'd0,16'h0000,1'b0,3'd0,1'b0,3'd4,3'd0,16'hAAAA,16'h0000,2'b00,8'h00,1'b1};

    rst_n = 1'b0;
    idleAll();
    #3;
    chk("rst rd0",  64'(ifA.rd_data[0]), 64'h0);
    chk("rst rd1",  64'(ifA.rd_data[1]), 64'h0);
    chk("rst busy", 64'(ifA.rd_busy), 64'h0);
    chk("rst vec",  64'(ifA.busy_vec), 64'h0);
    chk("rst err",  64'(ifA.err_unclaimed), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // default configuration, BYPASS=1
    for (int i = 0; i < 15; i++) begin
      ifA.wr_en = vecs[i].wrEn; ifA.wr_addr = vecs[i].wrAddr; ifA.wr_data = vecs[i].wrData;
      ifA.claim_en = vecs[i].claimEn; ifA.claim_addr = vecs[i].claimAddr; ifA.flush = vecs[i].flush;
      ifA.rd_addr[0] = vecs[i].ra0; ifA.rd_addr[1] = vecs[i].ra1;
      @(negedge clk);
      chk($sformatf("v%0d rd0", i),  64'(ifA.rd_data[0]), 64'(vecs[i].exp0));
      chk($sformatf("v%0d rd1", i),  64'(ifA.rd_data[1]), 64'(vecs[i].exp1));
      chk($sformatf("v%0d rdbusy", i), 64'(ifA.rd_busy), 64'(vecs[i].expBusy));
      @(posedge clk); #1;
      chk($sformatf("v%0d busyvec", i), 64'(ifA.busy_vec), 64'(vecs[i].expVec));
      chk($sformatf("v%0d err", i), 64'(ifA.err_unclaimed), 64'(vecs[i].expErr));
    end
    idleAll();

    // BYPASS=0: same-cycle write is neither forwarded nor masks busy
    ifB.claim_en = 1'b1; ifB.claim_addr = 3'd5;
    @(posedge clk); #1;
    ifB.claim_en = 1'b0;
    ifB.wr_en = 1'b1; ifB.wr_addr = 3'd5; ifB.wr_data = 16'h1234; ifB.rd_addr[0] = 3'd5;
    @(negedge clk);
    chk("nobyp rd0 same", 64'(ifB.rd_data[0]), 64'h0000);
    chk("nobyp busy same", 64'(ifB.rd_busy[0]), 64'h1);
    @(posedge clk); #1;
    ifB.wr_en = 1'b0;
    #1;
    chk("nobyp rd0 next", 64'(ifB.rd_data[0]), 64'h1234);
    chk("nobyp busy next", 64'(ifB.rd_busy[0]), 64'h0);
    chk("nobyp vec", 64'(ifB.busy_vec), 64'h0);
    chk("nobyp err", 64'(ifB.err_unclaimed), 64'h0);

    // 32x16x3: claimed write to R15, then all three ports read it
    @(posedge clk); #1;
    ifC.claim_en = 1'b1; ifC.claim_addr = 4'd15;
    @(posedge clk); #1;
    ifC.claim_en = 1'b0;
    ifC.wr_en = 1'b1; ifC.wr_addr = 4'd15; ifC.wr_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    ifC.wr_en = 1'b0;
    for (int p = 0; p < 3; p++) ifC.rd_addr[p] = 4'd15;
    #1;
    for (int p = 0; p < 3; p++) chk($sformatf("wide rd%0d", p), 64'(ifC.rd_data[p]), 64'hDEADBEEF);
    chk("wide vec", 64'(ifC.busy_vec), 64'h0);
    chk("wide err", 64'(ifC.err_unclaimed), 64'h0);

    mBusy = 16'h0; mErr = 1'b0;
    for (int r = 0; r < 16; r++) mMem[r] = 32'h0;
    mMem[15] = 32'hDEADBEEF;

    // randomised claim/write/flush traffic against the reference scoreboard
    for (int c = 0; c < 200; c++) begin
      logic [15:0] nb;
      ifC.wr_en      = ($urandom_range(0, 2) == 0);
      ifC.wr_addr    = 4'($urandom_range(0, 15));
      ifC.wr_data    = 32'($urandom);
      ifC.claim_en   = ($urandom_range(0, 1) == 0);
      ifC.claim_addr = 4'($urandom_range(0, 15));
      ifC.flush      = ($urandom_range(0, 9) == 0);
      for (int p = 0; p < 3; p++) ifC.rd_addr[p] = 4'($urandom_range(0, 15));
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
        logic [3:0] a;
        logic       hit;
        a   = ifC.rd_addr[p];
        hit = ifC.wr_en && (ifC.wr_addr == a);
        chk($sformatf("rnd%0d rd%0d", c, p), 64'(ifC.rd_data[p]), 64'(hit ? ifC.wr_data : mMem[a]));
        chk($sformatf("rnd%0d rdbusy%0d", c, p), 64'(ifC.rd_busy[p]), 64'(hit ? 1'b0 : mBusy[a]));
      end
      if (ifC.wr_en && !mBusy[ifC.wr_addr] && !ifC.flush) mErr = 1'b1;
      nb = mBusy;
      if (ifC.flush) nb = 16'h0;
      else if (ifC.wr_en) nb[ifC.wr_addr] = 1'b0;
      if (ifC.claim_en) nb[ifC.claim_addr] = 1'b1;
      if (ifC.wr_en) mMem[ifC.wr_addr] = ifC.wr_data;
      mBusy = nb;
      @(posedge clk); #1;
      chk($sformatf("rnd%0d vec", c), 64'(ifC.busy_vec), 64'(mBusy));
      chk($sformatf("rnd%0d err", c), 64'(ifC.err_unclaimed), 64'(mErr));
    end
    idleAll();

    // mid-cycle asynchronous reset clears storage, scoreboard and error flag
    @(posedge clk); #1;
    ifA.claim_en = 1'b1; ifA.claim_addr = 3'd6;
    ifA.wr_en = 1'b1; ifA.wr_addr = 3'd3; ifA.wr_data = 16'hBEEF;
    @(posedge clk); #1;
    idleAll();
    ifA.rd_addr[0] = 3'd3;
    #1;
    chk("prerst rd0", 64'(ifA.rd_data[0]), 64'hBEEF);
    chk("prerst vec", 64'(ifA.busy_vec), 64'h40);
    chk("prerst err", 64'(ifA.err_unclaimed), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst rd0",  64'(ifA.rd_data[0]), 64'h0);
    chk("midrst rdbusy", 64'(ifA.rd_busy), 64'h0);
    chk("midrst vec",  64'(ifA.busy_vec), 64'h0);
    chk("midrst err",  64'(ifA.err_unclaimed), 64'h0);
    chk("midrst wide rd0", 64'(ifC.rd_data[0]), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file with an integrated per-register busy scoreboard; next generation of the LC-3 8x16 regfile.
- Sits between decode/issue (register reads and destination claims) and writeback (the Buss write port).
- Adds configurable width, depth and read-port count, write-to-read bypass, pipeline hazard tracking, flush, and a sticky protocol-error flag.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of registers; power of two, >= 2.
- NUM_RD, 2, number of combinational read ports (SR1, SR2, ...).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return the stored value only.
- AW, $clog2(NUM_REGS), address width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  destination register (DR).
- wr_data  in  DATA_W  writeback data (Buss).
- rd_addr  in  NUM_RD x AW  read addresses, one per port.
- rd_data  out  NUM_RD x DATA_W  read data, one per port.
- rd_busy  out  NUM_RD  1 = the addressed register has a pending producer (hazard).
- claim_en  in  1  issue strobe; marks claim_addr as having a pending write.
- claim_addr  in  AW  register being claimed.
- flush  in  1  clears all busy bits (branch/interrupt squash).
- busy_vec  out  NUM_REGS  current scoreboard state.
- err_unclaimed  out  1  sticky; a write hit a register that was not busy.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately including mid-cycle):
  - all registers clear to 0.
  - busy_vec clears to 0.
  - err_unclaimed clears to 0.
  - with all inputs at 0, rd_data = 0 and rd_busy = 0.
- Write: on posedge clk with wr_en=1, reg[wr_addr] <= wr_data. The value is visible through storage on the next cycle.
- Read: combinational, zero latency, for each port p:
  - If BYPASS=1 and wr_en=1 and wr_addr==rd_addr[p]: rd_data[p] = wr_data.
  - Otherwise: rd_data[p] = reg[rd_addr[p]].
  - Multiple ports on the same address return identical data.
- rd_busy[p]:
  - = busy[rd_addr[p]], except when BYPASS=1 and the same-cycle write hits that address, in which case rd_busy[p] = 0 (data is available).
  - With BYPASS=0 a same-cycle write does not mask busy.
- Scoreboard next-state per register r, evaluated in this priority order:
  1. Start from busy[r].
  2. If flush=1, the value becomes 0.
  3. Else if wr_en=1 and wr_addr==r, the value becomes 0.
  4. Then, if claim_en=1 and claim_addr==r, the value becomes 1. A claim always wins over a flush or a write in the same cycle, because it represents a new producer.
- Error flag:
  - err_unclaimed is set on posedge clk when wr_en=1, busy[wr_addr]=0 and flush=0.
  - It stays set until reset. The write itself still completes.
  - A write in the same cycle as flush never flags.
- Re-claim of an already-busy register: busy stays 1, no error. The scoreboard tracks a single outstanding producer per register.
- No X propagation: all outputs are defined for every address value, since addresses are always in range by construction.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W/NUM_REGS constants.
  - typedef reg_addr_t (logic [AW-1:0]) and reg_data_t.
  - localparam RST_VAL = '0.
- Sub-module regfile_scoreboard(clk, rst_n, claim_en, claim_addr, wr_en, wr_addr, flush, busy_vec, err_unclaimed) owns the busy bits and the error flag.
- regfile_mp instantiates the scoreboard and contains the storage array plus the per-port read/bypass muxes (generate loop over NUM_RD).

Test Plan:
- Reset: write 0xBEEF to R3, then pulse rst_n low mid-cycle -> rd_data for R3 reads 0x0000 immediately; busy_vec=0; err_unclaimed=0.
- Write/read and bypass:
  - Write 0x1234 to R5 while reading R5 on port 0 with BYPASS=1 -> rd_data[0]=0x1234 the same cycle, rd_busy[0]=0.
  - Repeat with BYPASS=0 -> the old value (0x0000) the same cycle, 0x1234 the next cycle.
- Hazard lifecycle: claim R2 in cycle 1 -> busy_vec[2]=1 from cycle 2 and rd_busy=1 on a port reading R2; write R2=0x00AA in cycle 4 -> busy clears in cycle 5; err_unclaimed stays 0.
- Simultaneous claim + write on R6 (R6 busy) -> R6 holds the written data and busy_vec[6] stays 1; simultaneous flush + claim R1 with R0 and R7 busy -> busy_vec = 8'b0000_0010.
- Unclaimed write: write R4=0x0F0F while busy[4]=0 -> R4=0x0F0F and err_unclaimed=1 on the next edge, staying 1 across further traffic until reset.
- Parametric: DATA_W=32, NUM_REGS=16, NUM_RD=3:
  - All three ports read R15 after writing 0xDEADBEEF -> all return 0xDEADBEEF.
  - Randomised claim/write/flush sequence checked against a reference scoreboard model.
